classify_ctrl: RTL and testbench

Sequencer for the 10-class argmax comparator at the output of the MNIST inference datapath. It collects the serially produced output-layer scores for one image and packs them into the comparator's wide score vector. It then pulses the comparator's valid, waits for its ready, and captures the predicted class. The prediction is returned to the downstream consumer over a valid/ready handshake, tagged with an image counter and error flags.

---
 rtl/classify_ctrl_pkg.sv | 14 +
 rtl/classify_ctrl_if.sv | 54 +++++
 rtl/classify_ctrl_score_packer.sv | 37 +++
 rtl/classify_ctrl.sv | 118 +++++++++++
 tb/tb_classify_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/classify_ctrl_pkg.sv
// classify_ctrl_pkg: shared types and constants for the argmax sequencer.
// Holds the FSM state enum, the fixed class count, the class code width,
// the timeout class code and the default score width.
package classify_ctrl_pkg;

  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT, OUTPUT} state_e;

  localparam int NUM_CLASS  = 10;   // comparator is 10-way, not tunable
  localparam int CLS_W      = 4;
  localparam int DEF_DATA_W = 30;

  localparam logic [CLS_W-1:0] CLS_TIMEOUT = 4'hF;

endpackage

// File: rtl/classify_ctrl_if.sv
// classify_ctrl_if: score stream, comparator and result channels of the
// argmax sequencer.
//   score_*        : inbound score stream (valid/ready, last marks 10th score)
//   cmp_*          : comparator side (packed scores, start pulse, result)
//   res_*, err_*   : outbound result (valid/ready) plus sticky error flags
//   label, acc_correct, res_match : only with CLASSIFY_ACC_CNT_EN defined
// Modports: slave = classify_ctrl, master = surrounding datapath.
interface classify_ctrl_if
  import classify_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_W,
  parameter int ID_WIDTH   = 16
);
  logic                            score_valid;
  logic                            score_ready;
  logic [DATA_WIDTH-1:0]           score_data;
  logic                            score_last;
  logic [DATA_WIDTH*NUM_CLASS-1:0] cmp_layer_out;
  logic                            cmp_valid;
  logic                            cmp_ready;
  logic [7:0]                      cmp_predict;
  logic                            res_valid;
  logic                            res_ready;
  logic [CLS_W-1:0]                res_class;
  logic [ID_WIDTH-1:0]             res_id;
  logic                            err_frame;
  logic                            err_timeout;
`ifdef CLASSIFY_ACC_CNT_EN
  logic [CLS_W-1:0]                label;
  logic [ID_WIDTH-1:0]             acc_correct;
  logic                            res_match;
`endif

  modport slave (
`ifdef CLASSIFY_ACC_CNT_EN
    input  label,
    output acc_correct, res_match,
`endif
    input  score_valid, score_data, score_last, cmp_ready, cmp_predict, res_ready,
    output score_ready, cmp_layer_out, cmp_valid, res_valid, res_class, res_id,
           err_frame, err_timeout
  );

  modport master (
`ifdef CLASSIFY_ACC_CNT_EN
    output label,
    input  acc_correct, res_match,
`endif
    output score_valid, score_data, score_last, cmp_ready, cmp_predict, res_ready,
    input  score_ready, cmp_layer_out, cmp_valid, res_valid, res_class, res_id,
           err_frame, err_timeout
  );

endinterface

// File: rtl/classify_ctrl_score_packer.sv
// classify_ctrl_score_packer: slot registers for one image's class scores.
//   clk, rst : clock, synchronous active-high reset (clears slots and idx)
//   wr_en    : write wr_data into slot idx and advance idx
//   wr_last  : score_last of the written score; restarts idx at 0
//   idx      : next slot to be written
//   vec      : packed slots, class k at [k*DATA_WIDTH +: DATA_WIDTH]
module classify_ctrl_score_packer
  import classify_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            wr_last,
  output logic [CLS_W-1:0]                idx,
  output logic [NUM_CLASS*DATA_WIDTH-1:0] vec
);

  logic [NUM_CLASS-1:0][DATA_WIDTH-1:0] slot;

  // An early last aborts the image; the stale slots are simply overwritten
  // by the next image, so only idx needs restarting.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      idx  <= '0;
    end else if (wr_en) begin
      slot[idx] <= wr_data;
      idx       <= (wr_last || idx == CLS_W'(NUM_CLASS-1)) ? '0 : idx + 1'b1;
    end
  end

  assign vec = slot;

endmodule

// File: rtl/classify_ctrl.sv
// classify_ctrl: sequencer for the 10-class argmax comparator.
// Collects 10 serial scores, pulses the comparator, waits (bounded by
// CMP_TIMEOUT, min 2) for its answer and hands the class downstream tagged
// with an image counter and sticky error flags.
//   clk, rst : clock, synchronous active-high reset
//   bus      : classify_ctrl_if.slave (score, comparator, result channels)
// Optional feature macro CLASSIFY_ACC_CNT_EN: label capture, res_match and
// the acc_correct counter.
module classify_ctrl
  import classify_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_W,
  parameter int CMP_TIMEOUT = 8,
  parameter int ID_WIDTH    = 16
) (
  input  logic           clk,
  input  logic           rst,
  classify_ctrl_if.slave bus
);

  localparam int               CNT_W    = $clog2(CMP_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMP_TIMEOUT-1);

  state_e              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CLS_W-1:0]    idx;
  logic [CLS_W-1:0]    res_class_q;
  logic [ID_WIDTH-1:0] res_id_q;
  logic                err_frame_q, err_timeout_q;
  logic                score_acc, last_slot, res_hs;
  logic                unused_predict_hi;

  // score_ready is held low while rst is asserted so every output reads 0
  // during reset, then rises as soon as rst drops.
  assign bus.score_ready = (state == COLLECT) & ~rst;
  assign bus.cmp_valid   = (state == ISSUE);
  assign bus.res_valid   = (state == OUTPUT);
  assign bus.res_class   = res_class_q;
  assign bus.res_id      = res_id_q;
  assign bus.err_frame   = err_frame_q;
  assign bus.err_timeout = err_timeout_q;

  assign score_acc = bus.score_valid & bus.score_ready;
  assign last_slot = (idx == CLS_W'(NUM_CLASS-1));
  assign res_hs    = bus.res_valid & bus.res_ready;

  assign unused_predict_hi = ^bus.cmp_predict[7:4];

  classify_ctrl_score_packer #(.DATA_WIDTH(DATA_WIDTH)) u_score_packer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (score_acc),
    .wr_data (bus.score_data),
    .wr_last (bus.score_last),
    .idx     (idx),
    .vec     (bus.cmp_layer_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (score_acc && last_slot)                state_nxt = ISSUE;
      ISSUE:                                              state_nxt = WAIT;
      WAIT:    if (bus.cmp_ready || cnt == CNT_LAST)      state_nxt = OUTPUT;
      OUTPUT:  if (bus.res_ready)                         state_nxt = COLLECT;
      default:                                            state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COLLECT;
      cnt           <= '0;
      res_class_q   <= '0;
      res_id_q      <= '0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        // last on a non-final slot (abort) or missing on slot 9: misframed
        COLLECT: if (score_acc && (bus.score_last != last_slot)) err_frame_q <= 1'b1;
        ISSUE:   cnt <= '0;
        WAIT: begin
          if (bus.cmp_ready) begin
            res_class_q <= bus.cmp_predict[CLS_W-1:0];
          end else if (cnt == CNT_LAST) begin
            res_class_q   <= CLS_TIMEOUT;
            err_timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUTPUT:  if (res_hs) res_id_q <= res_id_q + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CLASSIFY_ACC_CNT_EN
  logic [CLS_W-1:0]    label_q;
  logic [ID_WIDTH-1:0] acc_q;

  assign bus.res_match   = (state == OUTPUT) && (res_class_q == label_q);
  assign bus.acc_correct = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      label_q <= '0;
      acc_q   <= '0;
    end else begin
      if (score_acc && idx == '0) label_q <= bus.label;
      if (res_hs && bus.res_match) acc_q  <= acc_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_classify_ctrl.sv
module tb_classify_ctrl;
  import classify_ctrl_pkg::*;

  localparam int DW  = 30;
  localparam int IDW = 16;
  localparam int TMO = 8;
  localparam int VW  = DW*NUM_CLASS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  classify_ctrl_if #(.DATA_WIDTH(DW), .ID_WIDTH(IDW)) bus ();

  classify_ctrl #(.DATA_WIDTH(DW), .CMP_TIMEOUT(TMO), .ID_WIDTH(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // reference state
  int sc [NUM_CLASS];
  int cur_lbl = 0;
  int exp_id  = 0;
  int exp_acc = 0;
  bit exp_ef  = 0;
  bit exp_et  = 0;

  // comparator model knobs
  int cmp_dly  = 2;    // negedges after the valid pulse before ready
  bit cmp_hang = 0;
  int cmp_ovr  = -1;   // forced prediction, -1 = true argmax

  function automatic int argmax_vec(input logic [VW-1:0] v);
    int b = 0;
    logic signed [DW-1:0] bv, x;
    bv = v[DW-1:0];
    for (int k = 1; k < NUM_CLASS; k++) begin
      x = v[k*DW +: DW];
      if (x > bv) begin bv = x; b = k; end
    end
    return b;
  endfunction

  function automatic int argmax_sc();
    int b = 0;
    for (int k = 1; k < NUM_CLASS; k++) if (sc[k] > sc[b]) b = k;
    return b;
  endfunction

  function automatic logic [VW-1:0] pack_sc();
    logic [VW-1:0] v;
    for (int k = 0; k < NUM_CLASS; k++) v[k*DW +: DW] = sc[k][DW-1:0];
    return v;
  endfunction

  task automatic rnd_sc();
    for (int k = 0; k < NUM_CLASS; k++) sc[k] = int'($urandom) >>> 2;
    cur_lbl = $urandom_range(0, 9);
  endtask

  // comparator: answers from the vector it was handed
  initial begin
    int p;
    bus.cmp_ready   = 1'b0;
    bus.cmp_predict = '0;
    forever begin
      @(negedge clk);
      if (bus.cmp_valid && !cmp_hang) begin
        p = (cmp_ovr >= 0) ? cmp_ovr : argmax_vec(bus.cmp_layer_out);
        repeat (cmp_dly) @(negedge clk);
        bus.cmp_ready   = 1'b1;
        bus.cmp_predict = 8'(p);
        @(negedge clk);
        bus.cmp_ready = 1'b0;
      end
    end
  end

  // send n scores from sc[], score_last on index last_pos (-1: none)
  task automatic send(input int n, input int last_pos);
    for (int i = 0; i < n; i++) begin
      int w;
      bus.score_valid = 1'b1;
      bus.score_data  = sc[i][DW-1:0];
      bus.score_last  = (i == last_pos);
`ifdef CLASSIFY_ACC_CNT_EN
      bus.label = 4'(cur_lbl);
`endif
      w = 0;
      while (!bus.score_ready && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) chk("score_ready_wait", 0, 1);
      @(negedge clk);
    end
    bus.score_valid = 1'b0;
    bus.score_last  = 1'b0;
    if (last_pos != NUM_CLASS-1) exp_ef = 1'b1;
  endtask

  // entered at the negedge of the cycle after the 10th accept (n=1)
  task automatic get_res(input int cls, input int lat, input int hold, input string tag);
    int n = 1;
    bit match;
    chk({tag, "_issue"}, bus.cmp_valid, 1);
    chk({tag, "_vec"}, bus.cmp_layer_out, pack_sc());
    while (!bus.res_valid && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_cls"}, bus.res_class, cls);
    chk({tag, "_id"}, bus.res_id, exp_id);
    chk({tag, "_ef"}, bus.err_frame, exp_ef);
    chk({tag, "_et"}, bus.err_timeout, exp_et);
    chk({tag, "_vec_hold"}, bus.cmp_layer_out, pack_sc());
    match = (cls == cur_lbl);
`ifdef CLASSIFY_ACC_CNT_EN
    chk({tag, "_match"}, bus.res_match, match);
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_v"}, bus.res_valid, 1);
      chk({tag, "_hold_cls"}, bus.res_class, cls);
      chk({tag, "_hold_id"}, bus.res_id, exp_id);
      chk({tag, "_hold_srdy"}, bus.score_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    exp_id = (exp_id + 1) & 32'hFFFF;
    if (match) exp_acc++;
    chk({tag, "_done_v"}, bus.res_valid, 0);
    chk({tag, "_done_srdy"}, bus.score_ready, 1);
`ifdef CLASSIFY_ACC_CNT_EN
    chk({tag, "_acc"}, bus.acc_correct, exp_acc);
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_srdy"}, bus.score_ready, 0);
    chk({tag, "_vec"}, bus.cmp_layer_out, 0);
    chk({tag, "_cv"}, bus.cmp_valid, 0);
    chk({tag, "_rv"}, bus.res_valid, 0);
    chk({tag, "_cls"}, bus.res_class, 0);
    chk({tag, "_id"}, bus.res_id, 0);
    chk({tag, "_ef"}, bus.err_frame, 0);
    chk({tag, "_et"}, bus.err_timeout, 0);
`ifdef CLASSIFY_ACC_CNT_EN
    chk({tag, "_acc"}, bus.acc_correct, 0);
`endif
  endtask

  initial begin
    int seen;
    int preds [3];
    int lbls  [3];
    bus.score_valid = 1'b0;
    bus.score_data  = '0;
    bus.score_last  = 1'b0;
    bus.res_ready   = 1'b0;
`ifdef CLASSIFY_ACC_CNT_EN
    bus.label = '0;
`endif
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;
    #1 chk("rst_rel_srdy", bus.score_ready, 1);

    // directed image, answer 2
    sc = '{5, -3, 100, 7, 0, -1, 99, 2, 3, 4};
    cur_lbl = 2;
    send(NUM_CLASS, NUM_CLASS-1);
    get_res(2, 4, 0, "dir");

    // back-to-back with the result stalled
    for (int i = 0; i < 2; i++) begin
      rnd_sc(); send(NUM_CLASS, NUM_CLASS-1); get_res(argmax_sc(), 4, 5, "b2b");
    end

    // random comparator latency inside the window
    for (int i = 0; i < 6; i++) begin
      rnd_sc();
      cmp_dly = $urandom_range(1, 8);
      send(NUM_CLASS, NUM_CLASS-1);
      get_res(argmax_sc(), 2 + cmp_dly, $urandom_range(0, 2), "rnd");
    end

    // ready on the very last WAIT cycle still wins over the timeout
    rnd_sc(); cmp_dly = 8;
    send(NUM_CLASS, NUM_CLASS-1);
    get_res(argmax_sc(), 10, 0, "lastwait");

    // ready only during ISSUE is ignored -> timeout
    rnd_sc(); cmp_dly = 0; exp_et = 1'b1;
    send(NUM_CLASS, NUM_CLASS-1);
    get_res(15, TMO + 2, 0, "issue_rdy");

    // hung comparator
    rnd_sc(); cmp_dly = 2; cmp_hang = 1'b1;
    send(NUM_CLASS, NUM_CLASS-1);
    get_res(15, TMO + 2, 1, "hang");
    cmp_hang = 1'b0;

    // early last on the 4th score aborts the image
    rnd_sc();
    send(4, 3);
    seen = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (bus.res_valid) seen++; end
    chk("abort_nores", seen, 0);
    chk("abort_ef", bus.err_frame, 1);
    chk("abort_srdy", bus.score_ready, 1);
    rnd_sc(); send(NUM_CLASS, NUM_CLASS-1);
    get_res(argmax_sc(), 4, 0, "post_abort");

    // reset in the middle of WAIT
    rnd_sc(); cmp_hang = 1'b1;
    send(NUM_CLASS, NUM_CLASS-1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    cmp_hang = 1'b0;
    exp_id = 0; exp_acc = 0; exp_ef = 1'b0; exp_et = 1'b0;
    #1 chk("rst_wait_rel_srdy", bus.score_ready, 1);

    // labels 2,5,7 against predictions 2,4,7
    lbls  = '{2, 5, 7};
    preds = '{2, 4, 7};
    for (int i = 0; i < 3; i++) begin
      rnd_sc(); cur_lbl = lbls[i]; cmp_ovr = preds[i];
      send(NUM_CLASS, NUM_CLASS-1);
      get_res(preds[i], 4, 0, "acc");
    end
    cmp_ovr = -1;
    chk("acc_total", 32'(exp_acc), 2);

    // 10th score without last: still complete, flagged
    rnd_sc(); send(NUM_CLASS, -1);
    get_res(argmax_sc(), 4, 0, "nolast");
    rnd_sc(); send(NUM_CLASS, NUM_CLASS-1);
    get_res(argmax_sc(), 4, 0, "after_nolast");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
